// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU and load writebacks onto a
// single write port, tracks pending destinations in a busy mask for WAW and
// operand hazard detection, and blocks issue for two cycles after a PC write.
module regfile_wb_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        issueValid,
    input  logic [3:0]  issueDest,
    output logic        issueReady,
    input  logic        aluValid,
    input  logic [3:0]  aluDest,
    input  logic [31:0] aluData,
    output logic        aluReady,
    input  logic        ldValid,
    input  logic [3:0]  ldDest,
    input  logic [31:0] ldData,
    output logic        ldReady,
    output logic        writeEnable,
    output logic [3:0]  writeDestination,
    output logic [31:0] writeData,
    output logic        writeToPC,
    input  logic [3:0]  readReg1,
    input  logic [3:0]  readReg2,
    output logic        hazardStall,
    output logic        wbOrphan
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN1,
        DRAIN2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] busy;
    logic        favour_ld;
    logic        issue_block;
    logic        alu_hs;
    logic        ld_hs;
    logic        issue_hs;

    // Round-robin grant; readies are forced low while reset is asserted
    always_comb begin
        aluReady = reset && aluValid && (!ldValid || !favour_ld);
        ldReady  = reset && ldValid  && (!aluValid || favour_ld);
    end

    // Issue acceptance, hazard detection and PC-write indication
    always_comb begin
        issueReady  = reset && !busy[issueDest] && !issue_block;
        hazardStall = busy[readReg1] | busy[readReg2];
        writeToPC   = writeEnable && (writeDestination == 4'hF);
        alu_hs      = aluValid && aluReady;
        ld_hs       = ldValid && ldReady;
        issue_hs    = issueValid && issueReady;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // FSM next state: any PC write (re)starts the two-cycle drain
    always_comb begin
        state_next = state;
        if (writeToPC) begin
            state_next = DRAIN1;
        end else begin
            case (state)
                RUN:     state_next = RUN;
                DRAIN1:  state_next = DRAIN2;
                DRAIN2:  state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // FSM outputs: issue is blocked outside RUN
    always_comb begin
        issue_block = (state != RUN);
    end

    // Busy mask: commit clears first, an accepted issue then sets. An issue to
    // an index being cleared this cycle is already refused since busy is still 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            logic [15:0] busy_n;
            busy_n = busy;
            if (writeEnable) busy_n[writeDestination] = 1'b0;
            if (issue_hs)    busy_n[issueDest] = 1'b1;
            busy <= busy_n;
        end
    end

    // Commit register: granted request appears one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            writeEnable      <= 1'b0;
            writeDestination <= '0;
            writeData        <= '0;
        end else begin
            writeEnable <= alu_hs || ld_hs;
            if (alu_hs) begin
                writeDestination <= aluDest;
                writeData        <= aluData;
            end else if (ld_hs) begin
                writeDestination <= ldDest;
                writeData        <= ldData;
            end
        end
    end

    // Round-robin pointer moves only on a handshake
    always_ff @(posedge clk) begin
        if (!reset)      favour_ld <= 1'b1;
        else if (alu_hs) favour_ld <= 1'b1;
        else if (ld_hs)  favour_ld <= 1'b0;
    end

    // Sticky flag for commits to registers that were never reserved
    always_ff @(posedge clk) begin
        if (!reset)                                     wbOrphan <= 1'b0;
        else if (writeEnable && !busy[writeDestination]) wbOrphan <= 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural model.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        reset;
    logic        issueValid;
    logic [3:0]  issueDest;
    logic        issueReady;
    logic        aluValid;
    logic [3:0]  aluDest;
    logic [31:0] aluData;
    logic        aluReady;
    logic        ldValid;
    logic [3:0]  ldDest;
    logic [31:0] ldData;
    logic        ldReady;
    logic        writeEnable;
    logic [3:0]  writeDestination;
    logic [31:0] writeData;
    logic        writeToPC;
    logic [3:0]  readReg1;
    logic [3:0]  readReg2;
    logic        hazardStall;
    logic        wbOrphan;

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .issueValid(issueValid), .issueDest(issueDest), .issueReady(issueReady),
        .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
        .ldValid(ldValid), .ldDest(ldDest), .ldData(ldData), .ldReady(ldReady),
        .writeEnable(writeEnable), .writeDestination(writeDestination),
        .writeData(writeData), .writeToPC(writeToPC),
        .readReg1(readReg1), .readReg2(readReg2),
        .hazardStall(hazardStall), .wbOrphan(wbOrphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  id;
        logic        av;
        logic [3:0]  ad;
        logic [31:0] adata;
        logic        lv;
        logic [3:0]  ld;
        logic [31:0] ldata;
        logic [3:0]  r1;
        logic [3:0]  r2;
    } ins_t;

    typedef struct {
        logic        ar;
        logic        lr;
        logic        ir;
        logic        we;
        logic [3:0]  wd;
        logic [31:0] wdat;
        logic        pc;
        logic        hz;
        logic        orph;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    int nvec  = 0;
    int nfail = 0;

    // Behavioural model state
    bit          m_busy [16];
    bit          m_we;
    logic [3:0]  m_wd;
    logic [31:0] m_wdat;
    bit          m_orph;
    bit          m_last_ld;   // most recent grant went to load
    int          m_block;     // cycles of issue blocking still to come

    function automatic ins_t mk_in(logic rst, logic iv, logic [3:0] id,
                                   logic av, logic [3:0] ad, logic [31:0] adata,
                                   logic lv, logic [3:0] ld, logic [31:0] ldata,
                                   logic [3:0] r1, logic [3:0] r2);
        ins_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.av = av; v.ad = ad; v.adata = adata;
        v.lv = lv; v.ld = ld; v.ldata = ldata; v.r1 = r1; v.r2 = r2;
        return v;
    endfunction

    function automatic outs_t mk_out(logic ar, logic lr, logic ir, logic we,
                                     logic [3:0] wd, logic [31:0] wdat,
                                     logic pc, logic hz, logic orph);
        outs_t o;
        o.ar = ar; o.lr = lr; o.ir = ir; o.we = we; o.wd = wd; o.wdat = wdat;
        o.pc = pc; o.hz = hz; o.orph = orph;
        return o;
    endfunction

    task automatic apply(ins_t v);
        reset = v.rst; issueValid = v.iv; issueDest = v.id;
        aluValid = v.av; aluDest = v.ad; aluData = v.adata;
        ldValid = v.lv; ldDest = v.ld; ldData = v.ldata;
        readReg1 = v.r1; readReg2 = v.r2;
    endtask

    task automatic idle_in();
        apply(mk_in(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0));
    endtask

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected outputs from the model state and current inputs
    function automatic outs_t model_out();
        outs_t e;
        bool_grants: begin
            if (!reset) begin
                e.ar = 1'b0;
                e.lr = 1'b0;
            end else if (aluValid && ldValid) begin
                e.ar = m_last_ld;
                e.lr = !m_last_ld;
            end else begin
                e.ar = aluValid;
                e.lr = ldValid;
            end
        end
        e.ir   = reset && !m_busy[issueDest] && (m_block == 0);
        e.we   = m_we;
        e.wd   = m_wd;
        e.wdat = m_wdat;
        e.pc   = m_we && (m_wd == 4'd15);
        e.hz   = m_busy[readReg1] || m_busy[readReg2];
        e.orph = m_orph;
        return e;
    endfunction

    function automatic void model_step();
        outs_t e;
        e = model_out();
        if (!reset) begin
            foreach (m_busy[k]) m_busy[k] = 1'b0;
            m_we = 0; m_wd = '0; m_wdat = '0; m_orph = 0; m_last_ld = 0; m_block = 0;
        end else begin
            if (m_we) begin
                if (!m_busy[m_wd]) m_orph = 1'b1;
                m_busy[m_wd] = 1'b0;
            end
            if (issueValid && e.ir) m_busy[issueDest] = 1'b1;
            if (e.ar) begin
                m_we = 1; m_wd = aluDest; m_wdat = aluData; m_last_ld = 0;
            end else if (e.lr) begin
                m_we = 1; m_wd = ldDest; m_wdat = ldData; m_last_ld = 1;
            end else begin
                m_we = 0;
            end
            if (e.pc)             m_block = 2;
            else if (m_block > 0) m_block = m_block - 1;
        end
    endfunction

    function automatic void check_outs(string tag, outs_t e);
        chk({tag, "_aluReady"},   32'(aluReady),    32'(e.ar));
        chk({tag, "_ldReady"},    32'(ldReady),     32'(e.lr));
        chk({tag, "_issueReady"}, 32'(issueReady),  32'(e.ir));
        chk({tag, "_writeEnable"},32'(writeEnable), 32'(e.we));
        if (e.we) begin
            chk({tag, "_writeDest"}, 32'(writeDestination), 32'(e.wd));
            chk({tag, "_writeData"}, writeData, e.wdat);
        end
        chk({tag, "_writeToPC"},  32'(writeToPC),   32'(e.pc));
        chk({tag, "_hazard"},     32'(hazardStall), 32'(e.hz));
        chk({tag, "_orphan"},     32'(wbOrphan),    32'(e.orph));
    endfunction

    task automatic sample(string tag);
        @(negedge clk);
        check_outs(tag, model_out());
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{mk_in(0,1,3,0,0,0,0,0,0,3,0), mk_out(0,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{mk_in(1,1,3,0,0,0,0,0,0,3,0), mk_out(0,0,1,0,0,0,0,0,0)};
        vecs[2]  = '{mk_in(1,0,3,1,3,32'hAAAAAAAA,0,0,0,3,0), mk_out(1,0,0,0,0,0,0,1,0)};
        vecs[3]  = '{mk_in(1,0,3,0,0,0,0,0,0,3,0), mk_out(0,0,0,1,3,32'hAAAAAAAA,0,1,0)};
        vecs[4]  = '{mk_in(1,0,3,0,0,0,0,0,0,3,0), mk_out(0,0,1,0,0,0,0,0,0)};
        vecs[5]  = '{mk_in(1,1,1,0,0,0,0,0,0,1,2), mk_out(0,0,1,0,0,0,0,0,0)};
        vecs[6]  = '{mk_in(1,1,2,0,0,0,0,0,0,1,2), mk_out(0,0,1,0,0,0,0,1,0)};
        vecs[7]  = '{mk_in(1,0,0,1,1,32'h11111111,1,2,32'h22222222,1,2), mk_out(0,1,1,0,0,0,0,1,0)};
        vecs[8]  = '{mk_in(1,0,0,1,1,32'h11111111,1,2,32'h22222222,1,2), mk_out(1,0,1,1,2,32'h22222222,0,1,0)};
        vecs[9]  = '{mk_in(1,0,0,0,0,0,0,0,0,1,2), mk_out(0,0,1,1,1,32'h11111111,0,1,0)};
        vecs[10] = '{mk_in(1,0,0,0,0,0,0,0,0,1,2), mk_out(0,0,1,0,0,0,0,0,0)};

        m_block = 0;
        idle_in();
        reset = 1'b0;
        #1;
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        chk("rst_writeDest", 32'(writeDestination), 32'd0);
        chk("rst_writeData", writeData, 32'd0);

        // Directed table: basic writeback and dual-requester arbitration
        for (int k = 0; k < 11; k++) begin
            apply(vecs[k].i);
            @(negedge clk);
            check_outs($sformatf("tbl%0d", k), vecs[k].o);
            advance();
        end

        // WAW stall on back-to-back issue of R5
        idle_in(); issueValid = 1; issueDest = 4'd5;
        sample("waw1"); chk("waw1_ready", 32'(issueReady), 32'd1); advance();
        aluValid = 1; aluDest = 4'd5; aluData = 32'h55555555;
        sample("waw2"); chk("waw2_ready", 32'(issueReady), 32'd0); advance();
        aluValid = 0;
        sample("waw3"); chk("waw3_commit", 32'(writeEnable), 32'd1);
        chk("waw3_ready", 32'(issueReady), 32'd0); advance();
        sample("waw4"); chk("waw4_ready", 32'(issueReady), 32'd1); advance();
        idle_in(); aluValid = 1; aluDest = 4'd5;
        sample("waw5"); advance();
        idle_in(); sample("waw6"); advance();

        // PC write drains issue for two cycles; ALU commit still proceeds
        idle_in(); issueValid = 1; issueDest = 4'd15; sample("pc1"); advance();
        issueDest = 4'd4; sample("pc2"); advance();
        idle_in(); ldValid = 1; ldDest = 4'd15; ldData = 32'h00000040;
        sample("pc3"); chk("pc3_ldReady", 32'(ldReady), 32'd1); advance();
        idle_in(); aluValid = 1; aluDest = 4'd4; aluData = 32'h44444444;
        sample("pc4"); chk("pc4_writeToPC", 32'(writeToPC), 32'd1);
        chk("pc4_data", writeData, 32'h00000040); advance();
        idle_in(); issueValid = 1; issueDest = 4'd6;
        sample("pc5"); chk("pc5_ready", 32'(issueReady), 32'd0);
        chk("pc5_dest", 32'(writeDestination), 32'd4); advance();
        sample("pc6"); chk("pc6_ready", 32'(issueReady), 32'd0); advance();
        sample("pc7"); chk("pc7_ready", 32'(issueReady), 32'd1); advance();
        idle_in(); aluValid = 1; aluDest = 4'd6; sample("pc8"); advance();
        idle_in(); sample("pc9"); advance();

        // Orphan writeback to un-issued R7
        idle_in(); aluValid = 1; aluDest = 4'd7; aluData = 32'h77777777;
        sample("orp1"); chk("orp1_flag", 32'(wbOrphan), 32'd0); advance();
        idle_in(); sample("orp2"); chk("orp2_dest", 32'(writeDestination), 32'd7); advance();
        sample("orp3"); chk("orp3_flag", 32'(wbOrphan), 32'd1); advance();

        // Reset during a grant cycle discards the grant
        idle_in(); issueValid = 1; issueDest = 4'd8; sample("rg1"); advance();
        idle_in(); reset = 0; aluValid = 1; aluDest = 4'd8; readReg1 = 4'd8;
        sample("rg2"); chk("rg2_aluReady", 32'(aluReady), 32'd0); advance();
        idle_in(); readReg1 = 4'd8;
        sample("rg3"); chk("rg3_we", 32'(writeEnable), 32'd0);
        chk("rg3_orphan", 32'(wbOrphan), 32'd0);
        chk("rg3_hazard", 32'(hazardStall), 32'd0); advance();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 63) != 0);
            issueValid = $urandom_range(0, 1) == 1;
            issueDest  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            aluValid   = $urandom_range(0, 2) == 0;
            aluDest    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            aluData    = $urandom;
            ldValid    = $urandom_range(0, 2) == 0;
            ldDest     = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            ldData     = $urandom;
            readReg1   = 4'($urandom_range(0, 15));
            readReg2   = 4'($urandom_range(0, 15));
            sample($sformatf("rnd%0d", n));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
